// File: rtl/ltc2308_responder.sv
// ltc2308_responder: device-side emulator of the LTC2308 8-channel 12-bit ADC serial port.
// It answers a controller's CONVST/SCK/SDI with SDO results computed from parallel channel values.
//
// Ports:
//   clock        system clock, sole clock domain
//   reset_n      asynchronous active-low reset
//   convst       conversion start (async to clock); only its rising edge matters
//   sck          serial clock from the controller (async to clock)
//   sdi          serial config input, MSB first, sampled on SCK rise
//   sdo          serial result output, MSB first, advanced on SCK fall
//   ch_data      eight 12-bit channel values, ch n = ch_data[12n+11:12n]
//   busy         high while the emulated conversion runs (CONV_CYCLES clocks)
//   config_o     config word of the current conversion {S/D, O/S, S1, S0, UNI, SLP}
//   frame_count  CONVST rising edges since reset, wrapping
//   err_sck      one-cycle pulse for an SCK rise seen while busy
module ltc2308_responder #(
    parameter int unsigned CONV_CYCLES = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        convst,
    input  logic        sck,
    input  logic        sdi,
    output logic        sdo,
    input  logic [95:0] ch_data,
    output logic        busy,
    output logic [5:0]  config_o,
    output logic [15:0] frame_count,
    output logic        err_sck
);

    localparam int unsigned CntW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CntW-1:0] ConvLast = CntW'(CONV_CYCLES - 1);
    localparam logic [5:0] CfgReset = 6'b100010;

    typedef enum logic [1:0] {StIdle, StConvert, StShift} state_e;

    // Input synchronizers; bit 0 of each chain is the raw pin.
    logic [SYNC_STAGES-1:0] r_cv_sync, r_sck_sync, r_sdi_sync;
    logic [SYNC_STAGES:0]   w_cv_chain, w_sck_chain, w_sdi_chain;
    logic                   w_cv_s, w_sck_s, w_sdi_s;
    logic                   r_cv_q, r_sck_q, r_sdi_q;
    logic                   r_cv_rise, r_sck_rise, r_sck_fall;

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_conv_cnt;
    logic [3:0]      r_bit_cnt;
    logic [2:0]      r_rise_cnt;
    logic [4:0]      r_sdi_shreg;
    logic [5:0]      r_pend_cfg;
    logic            r_pend_vld;
    logic [5:0]      r_config;
    logic [11:0]     r_result;
    logic [15:0]     r_frame_cnt;
    logic            r_err;

    logic [5:0]  w_cfg_new;
    logic [2:0]  w_addr_a, w_addr_b;
    logic [11:0] w_ch_a, w_ch_b;
    logic [12:0] w_diff;
    logic [11:0] w_result;

    assign w_cv_chain  = {r_cv_sync, convst};
    assign w_sck_chain = {r_sck_sync, sck};
    assign w_sdi_chain = {r_sdi_sync, sdi};
    assign w_cv_s      = r_cv_sync[SYNC_STAGES-1];
    assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
    assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];

    // Synchronizers and registered edge detectors. r_sdi_q is aligned with the
    // edge pulses so the SDI value sampled on a detected SCK rise is coherent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cv_sync  <= '0;
            r_sck_sync <= '0;
            r_sdi_sync <= '0;
            r_cv_q     <= 1'b0;
            r_sck_q    <= 1'b0;
            r_sdi_q    <= 1'b0;
            r_cv_rise  <= 1'b0;
            r_sck_rise <= 1'b0;
            r_sck_fall <= 1'b0;
        end else begin
            r_cv_sync  <= w_cv_chain[SYNC_STAGES-1:0];
            r_sck_sync <= w_sck_chain[SYNC_STAGES-1:0];
            r_sdi_sync <= w_sdi_chain[SYNC_STAGES-1:0];
            r_cv_q     <= w_cv_s;
            r_sck_q    <= w_sck_s;
            r_sdi_q    <= w_sdi_s;
            r_cv_rise  <= w_cv_s & ~r_cv_q;
            r_sck_rise <= w_sck_s & ~r_sck_q;
            r_sck_fall <= ~w_sck_s & r_sck_q;
        end
    end

    // Result for the conversion being started: the pending config takes effect now.
    // Channel a is always ch[{S1,S0,O/S}]; b is its pair partner, which gives the
    // O/S swap for free in differential mode.
    always_comb begin
        w_cfg_new = r_pend_vld ? r_pend_cfg : r_config;
        w_addr_a  = {w_cfg_new[3:2], w_cfg_new[4]};
        w_addr_b  = {w_cfg_new[3:2], ~w_cfg_new[4]};
        w_ch_a    = ch_data[12*int'(w_addr_a) +: 12];
        w_ch_b    = ch_data[12*int'(w_addr_b) +: 12];
        w_diff    = {1'b0, w_ch_a} - {1'b0, w_ch_b};
        w_result  = '0;
        if (w_cfg_new[5]) begin
            w_result = w_cfg_new[1] ? w_ch_a : {~w_ch_a[11], w_ch_a[10:0]};
        end else if (w_cfg_new[1]) begin
            w_result = w_diff[12] ? 12'h000 : w_diff[11:0];
        end else begin
            w_result = w_diff[12:1];
        end
    end

    // Next state; a CONVST rise overrides everything.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:    w_state_d = StIdle;
            StConvert: if (r_conv_cnt == ConvLast) w_state_d = StShift;
            StShift:   w_state_d = StShift;
            default:   w_state_d = StIdle;
        endcase
        if (r_cv_rise) w_state_d = StConvert;
    end

    always_comb begin
        busy = (r_state == StConvert);
        sdo  = 1'b0;
        if (r_state == StShift && r_bit_cnt < 4'd12) sdo = r_result[4'd11 - r_bit_cnt];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_conv_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_rise_cnt  <= '0;
            r_sdi_shreg <= '0;
            r_pend_cfg  <= '0;
            r_pend_vld  <= 1'b0;
            r_config    <= CfgReset;
            r_result    <= '0;
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            // SCK edges coinciding with a CONVST rise are discarded.
            r_err <= r_sck_rise & ~r_cv_rise & (r_state == StConvert);
            if (r_cv_rise) begin
                r_config    <= w_cfg_new;
                r_pend_vld  <= 1'b0;
                r_result    <= w_result;
                r_conv_cnt  <= '0;
                r_bit_cnt   <= '0;
                r_rise_cnt  <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                if (r_state == StConvert) r_conv_cnt <= r_conv_cnt + CntW'(1);
                if (r_state == StShift) begin
                    if (r_sck_fall && r_bit_cnt != 4'd12) r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_sck_rise && r_rise_cnt != 3'd6) begin
                        r_sdi_shreg <= {r_sdi_shreg[3:0], r_sdi_q};
                        r_rise_cnt  <= r_rise_cnt + 3'd1;
                        if (r_rise_cnt == 3'd5) begin
                            r_pend_cfg <= {r_sdi_shreg, r_sdi_q};
                            r_pend_vld <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign config_o    = r_config;
    assign frame_count = r_frame_cnt;
    assign err_sck     = r_err;

endmodule

// File: tb/tb_ltc2308_responder.sv
// Bench for ltc2308_responder: drives controller-side frames, predicts each frame's result,
// config and frame count into a scoreboard queue, and compares against the shifted-out bits.
module tb_ltc2308_responder;

    localparam int Conv = 64;
    localparam int Half = 8;

    logic        clock = 1'b0;
    logic        reset_n, convst, sck, sdi;
    logic        sdo, busy, err_sck;
    logic [5:0]  config_o;
    logic [15:0] frame_count;
    logic [11:0] ch [8];
    logic [95:0] ch_data;

    assign ch_data = {ch[7], ch[6], ch[5], ch[4], ch[3], ch[2], ch[1], ch[0]};

    ltc2308_responder #(.CONV_CYCLES(Conv), .SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .convst      (convst),
        .sck         (sck),
        .sdi         (sdi),
        .sdo         (sdo),
        .ch_data     (ch_data),
        .busy        (busy),
        .config_o    (config_o),
        .frame_count (frame_count),
        .err_sck     (err_sck)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;
    int err_seen = 0;

    always @(negedge clock) if (err_sck) err_seen <= err_seen + 1;

    typedef struct {
        logic [11:0] res;
        logic [5:0]  cfg;
        logic [15:0] fc;
    } exp_t;
    exp_t sb[$];

    logic [5:0]  m_cfg, m_pend;
    bit          m_pvld;
    logic [15:0] m_fc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour of the converter for a given config word.
    function automatic logic [11:0] model_result(input logic [5:0] c);
        int p, a, b, d, v;
        p = int'(c[3]) * 2 + int'(c[2]);
        if (c[5]) begin
            v = int'(ch[2 * p + int'(c[4])]);
            if (!c[1]) v = v ^ 'h800;
            return 12'(v);
        end
        a = c[4] ? int'(ch[2 * p + 1]) : int'(ch[2 * p]);
        b = c[4] ? int'(ch[2 * p]) : int'(ch[2 * p + 1]);
        d = a - b;
        if (c[1]) return (d < 0) ? 12'h000 : 12'(d);
        return 12'((d >>> 1) & 'hFFF);
    endfunction

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_sdo"}, sdo, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_cfg"}, config_o, 6'b100010);
        check_eq({tag, "_fc"}, frame_count, 0);
        check_eq({tag, "_err"}, err_sck, 0);
    endtask

    // One controller frame: CONVST, wait out busy, then nsck SCK periods.
    task automatic run_frame(input logic [5:0] sdi_word, input int nsck, input bit inject_err);
        exp_t e;
        int cnt, err0;
        bit sdo_bad;
        logic [11:0] got;
        @(negedge clock);
        convst = 1'b1;
        if (m_pvld) m_cfg = m_pend;
        m_pvld = 1'b0;
        m_fc   = m_fc + 16'd1;
        e.res = model_result(m_cfg);
        e.cfg = m_cfg;
        e.fc  = m_fc;
        sb.push_back(e);
        err0 = err_seen;
        cnt = 0;
        while (!busy && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        convst = 1'b0;
        check_eq("busy_rise", busy, 1);
        cnt = 0;
        sdo_bad = 1'b0;
        while (busy && cnt < 200) begin
            if (sdo) sdo_bad = 1'b1;
            if (inject_err && cnt == 10) sck = 1'b1;
            if (inject_err && cnt == 20) sck = 1'b0;
            cnt++;
            @(negedge clock);
        end
        check_eq("busy_len", cnt, Conv);
        if (inject_err) begin
            check_eq("err_pulses", err_seen - err0, 1);
            check_eq("sdo_in_busy", sdo_bad, 0);
        end
        got = '0;
        for (int i = 0; i < nsck; i++) begin
            sdi = (i < 6) ? sdi_word[5 - i] : 1'b0;
            repeat (Half) @(negedge clock);
            got = {got[10:0], sdo};
            sck = 1'b1;
            repeat (Half) @(negedge clock);
            sck = 1'b0;
        end
        if (sb.size() == 0) begin
            check_eq("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_eq("result", got, e.res >> (12 - nsck));
            check_eq("config", config_o, e.cfg);
            check_eq("frame_count", frame_count, e.fc);
        end
        if (nsck >= 6) begin
            m_pend = sdi_word;
            m_pvld = 1'b1;
        end
        if (nsck == 12) begin
            repeat (Half) @(negedge clock);
            check_eq("sdo_tail", sdo, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        convst  = 1'b0;
        sck     = 1'b0;
        sdi     = 1'b0;
        for (int i = 0; i < 8; i++) ch[i] = 12'h000;
        m_cfg  = 6'b100010;
        m_pend = 6'b000000;
        m_pvld = 1'b0;
        m_fc   = 16'd0;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        ch[0] = 12'hABC;
        run_frame(6'b110010, 12, 1'b0);   // default cfg: ch0
        ch[1] = 12'h123;
        run_frame(6'b100000, 12, 1'b0);   // ch1 SE uni
        ch[0] = 12'h800;
        run_frame(6'b100000, 12, 1'b0);   // ch0 SE bipolar -> 000
        ch[0] = 12'h7FF;
        run_frame(6'b000010, 12, 1'b0);   // -> FFF
        ch[0] = 12'h100;
        ch[1] = 12'h300;
        run_frame(6'b010010, 12, 1'b0);   // diff uni, negative -> 000
        run_frame(6'b000000, 12, 1'b0);   // diff uni swapped -> 200
        run_frame(6'b100010, 4, 1'b0);    // diff bipolar -> F00, only 4 SDI bits
        run_frame(6'b100010, 12, 1'b1);   // config unchanged; SCK pulse during busy
        ch[0] = 12'hABC;
        run_frame(6'b110010, 5, 1'b0);    // aborted after 5 bits
        run_frame(6'b100010, 12, 1'b0);   // restart, config still ch0 SE uni

        // Reset while shifting a word of ones.
        ch[0] = 12'hFFF;
        run_frame(6'b100010, 3, 1'b0);
        repeat (Half) @(negedge clock);
        check_eq("pre_reset_sdo", sdo, 1);
        reset_n = 1'b0;
        #1;
        check_reset_values("midshift_reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ltc2308_responder.md
# ltc2308_responder

Synthesizable device-side emulator of the LTC2308 8-channel 12-bit ADC serial interface. It answers the ADC controller's CONVST/SCK/SDI with SDO conversion results taken from parallel channel registers. It is used for hardware-in-the-loop and FPGA-internal testing of the ADC controller path without the physical converter. It sits between the controller's conduit pins and a register bank, or a stimulus source, that supplies channel values.

## Interface
Parameters:
- CONV_CYCLES, 64: clock cycles of emulated conversion time. Minimum 4.
- SYNC_STAGES, 2: input synchronizer depth for convst/sck/sdi.

Ports:
- clock  in  1  system clock; sole clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- convst  in  1  conversion start from controller; asynchronous to clock.
- sck  in  1  serial clock from controller; asynchronous to clock.
- sdi  in  1  serial config input, MSB first.
- sdo  out  1  serial result output, MSB first.
- ch_data  in  96  eight 12-bit channel values; ch n = ch_data[12n+11:12n].
- busy  out  1  high while emulated conversion is in progress.
- config_o  out  6  config word in effect for the current conversion: {S/D, O/S, S1, S0, UNI, SLP}.
- frame_count  out  16  number of CONVST rising edges since reset; wraps at 16'hFFFF to 0.
- err_sck  out  1  one-cycle pulse on an SCK rising edge seen while busy.

## Operation
- convst, sck and sdi each pass through SYNC_STAGES flops, then a rising- and falling-edge detector. All behaviour keys off the detected edges.
- Config pipeline follows the LTC2308 rule:
  - SDI bits received in frame N configure the conversion started at the CONVST of frame N+1.
  - Reset config is 6'b100010: channel 0, single-ended, unipolar.
- FSM states: IDLE, CONVERT, SHIFT.
  - IDLE -> CONVERT on CONVST rise.
  - CONVERT -> SHIFT when the conversion counter reaches CONV_CYCLES-1.
  - SHIFT -> CONVERT on CONVST rise.
  - A CONVST rise in any state, including mid-CONVERT or mid-SHIFT, aborts the current activity. It then:
    - loads pending config into config_o (only if the pending config is valid);
    - latches the selected channel data and computes the result;
    - clears the bit counters and restarts CONVERT;
    - increments frame_count.
- Result computation is performed at the CONVST rise and the value is held for the whole frame:
  - Channel address is {S1,S0,O/S}.
  - S/D=1, UNI=1: result = ch[addr].
  - S/D=1, UNI=0: result = ch[addr] with the MSB inverted (offset binary to two's complement).
  - S/D=0: pair p = {S1,S0}; with O/S=0, a = ch[2p] and b = ch[2p+1]; with O/S=1 the two are swapped. Diff = a-b computed at 13 bits.
    - UNI=1: result = diff<0 ? 0 : diff[11:0].
    - UNI=0: result = diff[12:1], two's complement.
  - SLP is stored and reported only; it has no effect on the result.
- SHIFT, SDO side:
  - sdo = result[11] on entry to SHIFT.
  - Each SCK fall advances one bit.
  - After 12 falls, sdo = 0 until the next CONVST.
- SHIFT, SDI side:
  - SDI is sampled on the SCK rise into a 6-bit shift register.
  - On the 6th rise the register is copied to pending config and marked valid.
  - Further SDI bits in the frame are ignored.
  - With fewer than 6 rises, pending config is not updated.
- CONVERT: sdo = 0 and busy = 1. SCK edges are ignored apart from generating err_sck.
- Reset values: sdo 0, busy 0, config_o 6'b100010, frame_count 0, err_sck 0, state IDLE, pending config invalid.

## Timing
- Input-to-edge latency: SYNC_STAGES+1 clocks.
- busy rises 1 clock after CONVST rise detection and stays high exactly CONV_CYCLES clocks.
- sdo MSB is valid in the same cycle busy falls.
- sdo updates 1 clock after SCK fall detection, i.e. SYNC_STAGES+2 clocks after the pin edge.
- Supported SCK high and low time: at least SYNC_STAGES+3 clocks each. Faster SCK is unsupported; behaviour is undefined apart from no lockup.
- A CONVST rise and an SCK edge detected in the same cycle: CONVST wins and the SCK edge is discarded.
- A CONVST pulse must be high for at least 1 clock after synchronization. Only the rising edge matters.
- frame_count increments 1 clock after CONVST rise detection.

## Test plan
- Reset, then CONVST with ch0=12'hABC and 12 SCKs at 8-clock half period -> sdo bits 1010_1011_1100, busy high 64 clocks, config_o=6'b100010, frame_count=1.
- Frame 1 SDI=6'b110010 (ch1 SE uni), ch1=12'h123 -> frame 1 returns ch0; frame 2 returns 12'h123 with config_o=6'b110010.
- Config 6'b100000 (ch0 SE bipolar), ch0=12'h800 -> 12'h000; ch0=12'h7FF -> 12'hFFF.
- Differential: config 6'b000010, ch0=12'h100, ch1=12'h300 -> 12'h000; O/S=1 (6'b010010) -> 12'h200; bipolar 6'b000000 -> 12'hF00.
- Only 4 SDI bits sent in a frame -> the next frame keeps the previous config_o. SCK pulse during busy -> err_sck pulses once and sdo stays 0.
- CONVST reissued after 5 shifted bits -> counters restart, the new result's MSB appears after CONV_CYCLES. Assert reset_n mid-SHIFT -> all outputs return to reset values immediately.
